// File: rtl/gshare_predictor_if.sv
// Fetch/ALU-side bundle for the gshare predictor: prediction request,
// branch resolution, stall, and the status/statistics it reports back.
interface gshare_predictor_if #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int GHR_SIZE      = 8,
  parameter int STAT_WIDTH    = 16
);
  logic                     i_Stall;
  logic                     i_pred_valid;
  logic [ADDRESS_WIDTH-1:0] i_pred_pc;
  logic                     o_pred_taken;
  logic [GHR_SIZE-1:0]      o_pred_ghr;
  logic                     i_res_valid;
  logic [ADDRESS_WIDTH-1:0] i_res_pc;
  logic [GHR_SIZE-1:0]      i_res_ghr;
  logic                     i_res_taken;
  logic                     i_res_mispredict;
  logic                     o_ready;
  logic [STAT_WIDTH-1:0]    o_branch_count;
  logic [STAT_WIDTH-1:0]    o_mispredict_count;

  modport master (
    output i_Stall, i_pred_valid, i_pred_pc,
    output i_res_valid, i_res_pc, i_res_ghr, i_res_taken, i_res_mispredict,
    input  o_pred_taken, o_pred_ghr, o_ready, o_branch_count, o_mispredict_count
  );

  modport slave (
    input  i_Stall, i_pred_valid, i_pred_pc,
    input  i_res_valid, i_res_pc, i_res_ghr, i_res_taken, i_res_mispredict,
    output o_pred_taken, o_pred_ghr, o_ready, o_branch_count, o_mispredict_count
  );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: speculative global history, PC^GHR
// indexed saturating counters trained at resolution, post-reset table sweep.
module gshare_predictor #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int INDEX_BITS    = 8,
  parameter int GHR_SIZE      = 8,
  parameter int CTR_BITS      = 2,
  parameter int STAT_WIDTH    = 16
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  gshare_predictor_if.slave  bp
);

  localparam int DEPTH = 2 ** INDEX_BITS;
  localparam logic [CTR_BITS-1:0]   WEAK_T   = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [INDEX_BITS-1:0] LAST_IDX = {INDEX_BITS{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [INDEX_BITS-1:0] hash_idx(
    input logic [INDEX_BITS-1:0] pc_lo,
    input logic [GHR_SIZE-1:0]   ghr
  );
    logic [INDEX_BITS-1:0] ghr_ext;
    ghr_ext = {INDEX_BITS{1'b0}};
    ghr_ext[GHR_SIZE-1:0] = ghr;
    return pc_lo ^ ghr_ext;
  endfunction

  function automatic logic [CTR_BITS-1:0] ctr_update(
    input logic [CTR_BITS-1:0] ctr,
    input logic                taken
  );
    logic [CTR_BITS-1:0] nxt;
    if (taken) begin
      if (ctr != {CTR_BITS{1'b1}}) nxt = ctr + {{(CTR_BITS-1){1'b0}}, 1'b1};
      else                         nxt = ctr;
    end else begin
      if (ctr != {CTR_BITS{1'b0}}) nxt = ctr - {{(CTR_BITS-1){1'b0}}, 1'b1};
      else                         nxt = ctr;
    end
    return nxt;
  endfunction

  function automatic logic [STAT_WIDTH-1:0] stat_inc(input logic [STAT_WIDTH-1:0] cnt);
    logic [STAT_WIDTH-1:0] nxt;
    if (cnt != {STAT_WIDTH{1'b1}}) nxt = cnt + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
    else                           nxt = cnt;
    return nxt;
  endfunction

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic                   run_s;
  logic                   init_wr_s;
  logic                   ready_r;
  logic [INDEX_BITS-1:0]  init_ptr_r;
  logic [GHR_SIZE-1:0]    ghr_r;
  logic [GHR_SIZE-1:0]    ghr_nxt_s;
  logic [CTR_BITS-1:0]    pht_r [DEPTH];
  logic                   pht_wr_en_s;
  logic [INDEX_BITS-1:0]  pht_wr_idx_s;
  logic [CTR_BITS-1:0]    pht_wr_data_s;
  logic [INDEX_BITS-1:0]  pred_idx_s;
  logic [INDEX_BITS-1:0]  res_idx_s;
  logic                   pred_taken_s;
  logic [GHR_SIZE-1:0]    pred_ghr_s;
  logic                   pred_fire_s;
  logic                   res_fire_s;
  logic                   recover_s;
  logic [STAT_WIDTH-1:0]  branch_cnt_r;
  logic [STAT_WIDTH-1:0]  mispred_cnt_r;
  logic                   unused_bits_s;

  assign unused_bits_s = ^{bp.i_pred_pc[ADDRESS_WIDTH-1:INDEX_BITS],
                           bp.i_res_pc[ADDRESS_WIDTH-1:INDEX_BITS],
                           bp.i_res_ghr[GHR_SIZE-1]};

  // FSM state register
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) state_r <= ST_INIT;
    else         state_r <= state_nxt_s;
  end

  // FSM next state: sweep every entry once, then stay live
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_ptr_r == LAST_IDX) state_nxt_s = ST_RUN;
        else                        state_nxt_s = ST_INIT;
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    run_s     = 1'b0;
    init_wr_s = 1'b0;
    case (state_r)
      ST_INIT: init_wr_s = 1'b1;
      ST_RUN:  run_s     = 1'b1;
      default: begin
        run_s     = 1'b0;
        init_wr_s = 1'b0;
      end
    endcase
  end

  // Sweep pointer, deliberately blind to stall
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset)        init_ptr_r <= {INDEX_BITS{1'b0}};
    else if (init_wr_s) init_ptr_r <= init_ptr_r + {{(INDEX_BITS-1){1'b0}}, 1'b1};
    else                init_ptr_r <= init_ptr_r;
  end

  // Ready flag registered from the next state so it tracks state_r exactly
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) ready_r <= 1'b0;
    else         ready_r <= (state_nxt_s == ST_RUN);
  end

  assign pred_fire_s = run_s & bp.i_pred_valid & ~bp.i_Stall;
  assign res_fire_s  = run_s & bp.i_res_valid  & ~bp.i_Stall;
  assign recover_s   = res_fire_s & bp.i_res_mispredict;

  assign pred_idx_s = hash_idx(bp.i_pred_pc[INDEX_BITS-1:0], ghr_r);
  assign res_idx_s  = hash_idx(bp.i_res_pc[INDEX_BITS-1:0], bp.i_res_ghr);

  // Prediction path; forced quiet while the table is being swept
  always_comb begin
    if (run_s) begin
      pred_taken_s = pht_r[pred_idx_s][CTR_BITS-1];
      pred_ghr_s   = ghr_r;
    end else begin
      pred_taken_s = 1'b0;
      pred_ghr_s   = {GHR_SIZE{1'b0}};
    end
  end

  // Single PHT write port shared by the init sweep and resolve training
  always_comb begin
    if (init_wr_s) begin
      pht_wr_en_s   = 1'b1;
      pht_wr_idx_s  = init_ptr_r;
      pht_wr_data_s = WEAK_T;
    end else if (res_fire_s) begin
      pht_wr_en_s   = 1'b1;
      pht_wr_idx_s  = res_idx_s;
      pht_wr_data_s = ctr_update(pht_r[res_idx_s], bp.i_res_taken);
    end else begin
      pht_wr_en_s   = 1'b0;
      pht_wr_idx_s  = init_ptr_r;
      pht_wr_data_s = WEAK_T;
    end
  end

  // Counter table storage; no reset needed since the sweep rewrites it
  always_ff @(posedge i_Clk) begin
    if (pht_wr_en_s) pht_r[pht_wr_idx_s] <= pht_wr_data_s;
  end

  // Recovery from the resolving branch's snapshot beats the speculative shift
  always_comb begin
    if (recover_s)        ghr_nxt_s = {bp.i_res_ghr[GHR_SIZE-2:0], bp.i_res_taken};
    else if (pred_fire_s) ghr_nxt_s = {ghr_r[GHR_SIZE-2:0], pred_taken_s};
    else                  ghr_nxt_s = ghr_r;
  end

  // Speculative global history register
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) ghr_r <= {GHR_SIZE{1'b0}};
    else         ghr_r <= ghr_nxt_s;
  end

  // Saturating branch statistics
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      branch_cnt_r  <= {STAT_WIDTH{1'b0}};
      mispred_cnt_r <= {STAT_WIDTH{1'b0}};
    end else begin
      if (res_fire_s) branch_cnt_r <= stat_inc(branch_cnt_r);
      else            branch_cnt_r <= branch_cnt_r;
      if (recover_s)  mispred_cnt_r <= stat_inc(mispred_cnt_r);
      else            mispred_cnt_r <= mispred_cnt_r;
    end
  end

  assign bp.o_pred_taken       = pred_taken_s;
  assign bp.o_pred_ghr         = pred_ghr_s;
  assign bp.o_ready            = ready_r;
  assign bp.o_branch_count     = branch_cnt_r;
  assign bp.o_mispredict_count = mispred_cnt_r;

endmodule
